// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings, default oversampling
// ratio, data width and a parity helper.
package uart_defs;

    localparam int DATA_W         = 8;
    localparam int OVERSAMPLE_DEF = 8;

    // Receiver FSM state encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
    localparam logic [2:0] ST_PARITY    = 3'd5;

    // Parity bit a transmitter would send: even parity makes the total
    // number of ones even, odd parity makes it odd.
    function automatic logic uart_parity(input logic [DATA_W-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head output. Entries are
// individual registers so the head byte is visible the cycle after a push
// into an empty FIFO. A push while full succeeds only if a pop happens in
// the same cycle; a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_level;
    logic [WIDTH-1:0] w_entries [DEPTH];
    logic           w_do_pop;
    logic           w_do_push;

    assign empty     = (r_level == '0);
    assign full      = (r_level == LVL_FULL);
    assign level     = r_level;
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = w_entries[r_rd_ptr];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            logic [WIDTH-1:0] r_entry;
            // Storage entry gi, written when the write pointer selects it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_entry <= '0;
                else if (w_do_push && (r_wr_ptr == AW'(gi)))
                    r_entry <= wdata;
            end
            assign w_entries[gi] = r_entry;
        end
    endgenerate

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_level <= r_level + 1'b1;
            else if (!w_do_push && w_do_pop)
                r_level <= r_level - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: two-flop synchroniser, clkdiv prescaler, oversampling
// 8N1 frame decoder and RX FIFO with sticky framing/overflow flags.
// Optional feature macro UART_RX_PARITY_EN adds a parity bit between data
// and stop, the parity_en/parity_odd inputs and a sticky parity_err.
module uart_rx_core
    import uart_defs::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int W_DIV      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int W_LEVEL    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef UART_RX_PARITY_EN
    input  logic               parity_en,
    input  logic               parity_odd,
    output logic               parity_err,
`endif
    input  logic               enable,
    input  logic [W_DIV-1:0]   clkdiv,
    input  logic               rx,
    output logic [DATA_W-1:0]  rdata,
    output logic               rvalid,
    input  logic               rready,
    output logic [W_LEVEL-1:0] fifo_level,
    output logic               framing_err,
    output logic               overflow,
    input  logic               err_clr
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] HALF_LAST = OS_W'(OVERSAMPLE/2 - 1);
    localparam logic [OS_W-1:0] FULL_LAST = OS_W'(OVERSAMPLE - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_rx_prev;
    logic [W_DIV-1:0]  r_presc;
    logic [2:0]        r_state;
    logic [OS_W-1:0]   r_tick_cnt;
    logic [2:0]        r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_framing_err;
    logic              r_overflow;

    logic              w_rx_s;
    logic              w_fall;
    logic              w_start_det;
    logic              w_tick;
    logic [OS_W-1:0]   w_last;
    logic              w_sample;
    logic              w_stop_sample;
    logic              w_push;
    logic              w_pop;
    logic              w_frame_set;
    logic              w_ovf_set;
    logic              w_full;
    logic              w_empty;
    logic [W_LEVEL-1:0] w_level;
    logic              w_byte_ok;

    assign w_rx_s      = r_sync2;
    assign w_fall      = !w_rx_s && r_rx_prev;
    assign w_start_det = (r_state == ST_IDLE) && enable && w_fall;
    assign w_tick      = (r_presc == '0);
    // The start bit is sampled at its middle, every later bit a full bit on
    assign w_last      = (r_state == ST_START) ? HALF_LAST : FULL_LAST;
    assign w_sample    = w_tick && (r_tick_cnt == w_last);

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    logic w_par_set;
    assign w_par_set  = enable && (r_state == ST_PARITY) && w_sample &&
                        (w_rx_s != uart_parity(r_shift, parity_odd));
    assign w_byte_ok  = !r_par_bad;
    assign parity_err = r_parity_err;
`else
    assign w_byte_ok  = 1'b1;
`endif

    assign w_stop_sample = enable && (r_state == ST_STOP) && w_sample;
    assign w_push        = w_stop_sample && w_rx_s && w_byte_ok;
    assign w_frame_set   = w_stop_sample && !w_rx_s;
    assign w_pop         = rready && !w_empty;
    assign w_ovf_set     = w_push && w_full && !w_pop;

    assign rvalid      = !w_empty;
    assign fifo_level  = w_level;
    assign framing_err = r_framing_err;
    assign overflow    = r_overflow;

    // Two-flop synchroniser on the asynchronous line plus edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Prescaler: down-counter reloaded on tick and re-phased on a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_presc <= '0;
        else if (w_start_det || w_tick)
            r_presc <= clkdiv;
        else
            r_presc <= r_presc - 1'b1;
    end

    // Frame decoder FSM with tick and bit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
`endif
        end else if (!enable) begin
            // Abandon any partial frame; the FIFO and flags are untouched
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
        end else begin
            if (w_tick)
                r_tick_cnt <= w_sample ? '0 : r_tick_cnt + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_det) begin
                        r_state    <= ST_START;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                        r_par_bad  <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (w_sample)
                        r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_shift   <= {w_rx_s, r_shift[DATA_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= parity_en ? ST_PARITY : ST_STOP;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_sample) begin
                        r_par_bad <= w_par_set;
                        r_state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_sample)
                        r_state <= w_rx_s ? ST_IDLE : ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: begin
                    // Hold here through a break so it yields a single error
                    if (w_rx_s)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error event takes priority over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_frame_set)
                r_framing_err <= 1'b1;
            else if (err_clr)
                r_framing_err <= 1'b0;
            if (w_ovf_set)
                r_overflow <= 1'b1;
            else if (err_clr)
                r_overflow <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_parity_err <= 1'b0;
        else if (w_par_set)
            r_parity_err <= 1'b1;
        else if (err_clr)
            r_parity_err <= 1'b0;
    end
`endif

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (r_shift),
        .rdata (rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + randomized bench for uart_rx_core. A queue-based model of the
// receive FIFO and sticky flags supplies every expected value. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_uart_rx_core;

    localparam int OS      = 8;
    localparam int DEPTH   = 4;
    localparam int W_LEVEL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] clkdiv = 16'd1;
    logic        rx = 1'b1;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [W_LEVEL-1:0] fifo_level;
    logic        framing_err;
    logic        overflow;
    logic        err_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        parity_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_rx_core #(
        .OVERSAMPLE (OS),
        .W_DIV      (16),
        .FIFO_DEPTH (DEPTH),
        .W_LEVEL    (W_LEVEL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef UART_RX_PARITY_EN
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .parity_err  (parity_err),
`endif
        .enable      (enable),
        .clkdiv      (clkdiv),
        .rx          (rx),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .rready      (rready),
        .fifo_level  (fifo_level),
        .framing_err (framing_err),
        .overflow    (overflow),
        .err_clr     (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, stop bit
    function automatic logic [10:0] frame8(input logic [7:0] b, input logic stop);
        return {1'b1, stop, b, 1'b0};
    endfunction

    // Model of one good byte arriving with no pop in the same cycle
    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() == DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(b);
    endtask

    // Drives nbits bits plus two idle bit periods. rready is pulsed for one
    // cycle at pop_at; the frame is cut short (line high) at abort_at.
    // rise_at reports the cycle at which rvalid first rose (-1 if never).
    task automatic send_bits(input logic [10:0] bits, input int nbits,
                             input int pop_at, input int abort_at,
                             output int rise_at);
        int  bp;
        logic was_valid;
        bp = OS * (int'(clkdiv) + 1);
        rise_at = -1;
        was_valid = rvalid;
        for (int c = 0; c < (nbits + 2) * bp; c++) begin
            if (abort_at >= 0 && c == abort_at) begin
                rx = 1'b1;
                return;
            end
            if (!was_valid && rvalid && rise_at < 0) rise_at = c;
            rx = (c < nbits * bp) ? bits[c / bp] : 1'b1;
            rready = (c == pop_at);
            @(negedge clk);
        end
        rready = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int r;
        send_bits(frame8(b, 1'b1), 10, -1, -1, r);
        $display("frame sent byte=%02h", b);
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(rvalid), 32'd1);
            chk({tag, "_data"}, 32'(rdata), 32'(e));
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
        chk({tag, "_empty"}, 32'(rvalid), 32'd0);
        chk({tag, "_level0"}, 32'(fifo_level), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_ferr"}, 32'(framing_err), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
`ifdef UART_RX_PARITY_EN
        chk({tag, "_perr"}, 32'(parity_err), 32'd0);
`endif
    endtask

    initial begin
        int rise;
        int n;
        logic [7:0] b;

        // Reset state
        tick(3);
        chk_reset("reset");
        rst_n = 1'b1;
        enable = 1'b1;
        tick(5);

        // Basic frame 0xA5 at clkdiv=1 (16 clk per bit)
        send_bits(frame8(8'hA5, 1'b1), 10, -1, -1, rise);
        $display("frame sent byte=a5 rvalid_rise=%0d", rise);
        chk("basic_latency", 32'(rise >= 144 && rise <= 176), 32'd1);
        chk("basic_data", 32'(rdata), 32'hA5);
        chk("basic_level", 32'(fifo_level), 32'd1);
        rready = 1'b1; tick(); rready = 1'b0;
        chk("basic_pop_level", 32'(fifo_level), 32'd0);
        chk("basic_pop_valid", 32'(rvalid), 32'd0);

        // Randomized bursts at random clkdiv values
        for (int round = 0; round < 3; round++) begin
            clkdiv = 16'($urandom_range(0, 2));
            tick(8);
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(0, 255));
                send_byte(b);
                model_push(b);
            end
            chk("rand_level", 32'(fifo_level), 32'(exp_q.size()));
            drain("rand");
        end
        clkdiv = 16'd1;
        tick(8);

        // False start: 4-clk glitch
        rx = 1'b0; tick(4); rx = 1'b1; tick(40);
        $display("glitch sent len=4");
        chk("glitch_valid", 32'(rvalid), 32'd0);
        chk("glitch_ferr", 32'(framing_err), 32'd0);

        // Break: 20 bit periods low; err_clr in the stop-sample cycle loses
        rx = 1'b0;
        tick(154);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        tick(45);
        $display("break in progress");
        chk("break_ferr_set", 32'(framing_err), 32'd1);
        chk("break_no_push", 32'(rvalid), 32'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        tick(119);
        chk("break_single_evt", 32'(framing_err), 32'd0);
        rx = 1'b1;
        tick(32);
        send_byte(8'h3C);
        model_push(8'h3C);
        chk("after_break_ferr", 32'(framing_err), 32'd0);
        drain("after_break");

        // Overflow: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
            model_push(8'(i));
        end
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'(m_ovf));
        drain("ovf_order");
        err_clr = 1'b1; tick(); err_clr = 1'b0; m_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full boundary: pop lands in the push cycle of the fifth byte
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b);
            model_push(b);
        end
        b = 8'($urandom_range(0, 255));
        send_bits(frame8(b, 1'b1), 10, 154, -1, rise);
        $display("frame sent byte=%02h with pop in push cycle", b);
        void'(exp_q.pop_front());
        exp_q.push_back(b);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        drain("full_order");

        // Enable dropped mid-byte: partial byte discarded, FIFO retained
        send_byte(8'h11);
        model_push(8'h11);
        send_bits(frame8(8'h99, 1'b1), 10, -1, 80, rise);
        enable = 1'b0;
        tick(2);
        $display("enable dropped mid-frame");
        chk("en_level", 32'(fifo_level), 32'd1);
        chk("en_data", 32'(rdata), 32'h11);
        chk("en_ferr", 32'(framing_err), 32'd0);
        enable = 1'b1;
        tick(16);
        send_byte(8'h7E);
        model_push(8'h7E);
        drain("en_next");

        // Reset asserted mid-byte
        send_byte(8'h22);
        send_bits(frame8(8'h99, 1'b1), 10, -1, 80, rise);
        rst_n = 1'b0;
        tick(2);
        $display("reset asserted mid-frame");
        chk_reset("midrst");
        exp_q.delete();
        rst_n = 1'b1;
        tick(16);
        send_byte(8'h7E);
        model_push(8'h7E);
        drain("rst_next");

`ifdef UART_RX_PARITY_EN
        // Odd parity, 0x55 has four ones so the parity bit must be 1
        parity_en = 1'b1;
        parity_odd = 1'b1;
        tick(4);
        send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 11, -1, -1, rise);
        $display("frame sent byte=55 bad parity");
        chk("par_err", 32'(parity_err), 32'd1);
        chk("par_no_push", 32'(rvalid), 32'd0);
        chk("par_ferr", 32'(framing_err), 32'd0);
        send_bits({1'b1, 1'b1, 8'h55, 1'b0}, 11, -1, -1, rise);
        $display("frame sent byte=55 good parity");
        exp_q.push_back(8'h55);
        drain("par_good");
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("par_cleared", 32'(parity_err), 32'd0);
        parity_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
